crossbar_rr_router: RTL and testbench

// Non-blocking, parametrised N_INPUTS x N_OUTPUTS crossbar for the packet routing interconnect.
// - Each input has its own buffer and a routing-table entry (output index + enable), written over the control channel.
// - Several inputs may target one output; each output arbitrates round-robin.
// - Disjoint input->output paths transfer in the same cycle.

---
 rtl/crossbar_pkg.sv | 41 ++++
 rtl/crossbar_fifo.sv | 62 ++++++
 rtl/xbar_rr_arbiter.sv | 41 ++++
 rtl/crossbar_rr_router.sv | 172 +++++++++++++++++
 tb/tb_crossbar_rr_router.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/crossbar_pkg.sv
// Purpose: shared control-word layout and write-qualification helper for the crossbar router.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package crossbar_pkg;

  // Default control-word geometry; matches the router's default parameters.
  localparam int CTRL_BW     = 32;
  localparam int CTRL_AW     = 4;
  localparam int CTRL_IW     = 2;
  localparam int CTRL_OW     = 2;
  // write + en flag bits carried alongside the index fields
  localparam int CTRL_FLAG_W = 2;
  localparam int CTRL_PAD_W  = CTRL_BW - CTRL_AW - CTRL_IW - CTRL_OW - CTRL_FLAG_W;

  // MSB-first layout: addr | write | in_idx | out_idx | en | unused
  typedef struct packed {
    logic [CTRL_AW-1:0]    addr;
    logic                  write;
    logic [CTRL_IW-1:0]    in_idx;
    logic [CTRL_OW-1:0]    out_idx;
    logic                  en;
    logic [CTRL_PAD_W-1:0] pad;
  } ctrl_word_t;

  // A control word updates the table only when it is valid, a write, aimed at
  // this block, and both indices name ports that actually exist.
  function automatic logic ctrl_match(
    input logic        val,
    input logic        write,
    input int unsigned addr,
    input int unsigned block_addr,
    input int unsigned in_idx,
    input int unsigned n_inputs,
    input int unsigned out_idx,
    input int unsigned n_outputs
  );
    return val && write && (addr == block_addr) &&
           (in_idx < n_inputs) && (out_idx < n_outputs);
  endfunction

endpackage

// File: rtl/crossbar_fifo.sv
// Purpose: small generic FIFO with async-reset storage, head/tail pointers and occupancy count.
// Latency: 1 cycle push-to-head (registered storage, no bypass).
// Backpressure: full blocks push; pop is honoured even when full (push and pop may share a cycle).
module crossbar_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           cnt;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage, pointers and count advance on accepted push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (!do_push && do_pop) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Purpose: combinational round-robin arbiter with an optional grant lock for one crossbar output.
// Latency: 0 cycles (pure combinational).
// Backpressure: a set lock with its input still requesting pins the grant so a stalled beat stays stable.
module xbar_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          lock,
  input  logic [IW-1:0] lock_idx,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic found;

  // Locked input wins if it still requests; otherwise first requester at or after ptr.
  always_comb begin
    grant_idx    = '0;
    grant_onehot = '0;
    found        = 1'b0;
    any          = |req;
    if (lock && req[lock_idx]) begin
      grant_idx = lock_idx;
      found     = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && req[(int'(ptr) + k) % N]) begin
          found     = 1'b1;
          grant_idx = IW'((int'(ptr) + k) % N);
        end
      end
    end
    if (found) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/crossbar_rr_router.sv
// Purpose: N_INPUTS x N_OUTPUTS buffered crossbar; table-routed inputs, round-robin arbitration per output.
// Latency: 1 cycle from input accept to send_val (registered FIFO head, no bypass).
// Backpressure: recv_rdy = input FIFO not full; a stalled output holds its grant until the beat transfers.
module crossbar_rr_router
  import crossbar_pkg::*;
#(
  parameter int BIT_WIDTH         = CTRL_BW,
  parameter int N_INPUTS          = 4,
  parameter int N_OUTPUTS         = 4,
  parameter int QUEUE_DEPTH       = 2,
  parameter int ADDRESS_BIT_WIDTH = CTRL_AW,
  parameter int BLOCK_ADDRESS     = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_INPUTS-1:0][BIT_WIDTH-1:0]   recv_msg,
  input  logic [N_INPUTS-1:0]                  recv_val,
  output logic [N_INPUTS-1:0]                  recv_rdy,
  output logic [N_OUTPUTS-1:0][BIT_WIDTH-1:0]  send_msg,
  output logic [N_OUTPUTS-1:0]                 send_val,
  input  logic [N_OUTPUTS-1:0]                 send_rdy,
  input  logic [BIT_WIDTH-1:0]                 ctrl_msg,
  input  logic                                 ctrl_val,
  output logic                                 ctrl_rdy
);

  localparam int AW       = ADDRESS_BIT_WIDTH;
  localparam int IW       = $clog2(N_INPUTS);
  localparam int OW       = $clog2(N_OUTPUTS);
  localparam int EN_LSB   = BIT_WIDTH - (AW + IW + OW + CTRL_FLAG_W);
  localparam int OUT_LSB  = EN_LSB + 1;
  localparam int IN_LSB   = OUT_LSB + OW;
  localparam int WR_LSB   = IN_LSB + IW;
  localparam int ADDR_LSB = WR_LSB + 1;

  if (AW + IW + OW + CTRL_FLAG_W > BIT_WIDTH) begin : g_ctrl_width_check
    $error("crossbar_rr_router: control fields do not fit in BIT_WIDTH");
  end

  // Control-word fields
  logic [AW-1:0] ctrl_addr;
  logic          ctrl_write;
  logic [IW-1:0] ctrl_in;
  logic [OW-1:0] ctrl_out;
  logic          ctrl_en;
  logic          tbl_wr;
  logic          unused_ctrl;

  // Routing table
  logic [N_INPUTS-1:0]         route_en;
  logic [N_INPUTS-1:0][OW-1:0] route_out;

  // Input FIFOs
  logic [N_INPUTS-1:0]                push;
  logic [N_INPUTS-1:0]                pop;
  logic [N_INPUTS-1:0]                full;
  logic [N_INPUTS-1:0]                empty;
  logic [N_INPUTS-1:0][BIT_WIDTH-1:0] head;

  // Per-output arbitration state
  logic [N_OUTPUTS-1:0][N_INPUTS-1:0] req;
  logic [N_OUTPUTS-1:0][N_INPUTS-1:0] grant_oh;
  logic [N_OUTPUTS-1:0][IW-1:0]       grant_idx;
  logic [N_OUTPUTS-1:0]               any_req;
  logic [N_OUTPUTS-1:0]               xfer;
  logic [N_OUTPUTS-1:0][IW-1:0]       ptr;
  logic [N_OUTPUTS-1:0]               lock;
  logic [N_OUTPUTS-1:0][IW-1:0]       lock_idx;

  assign ctrl_rdy    = 1'b1;
  assign ctrl_addr   = ctrl_msg[ADDR_LSB +: AW];
  assign ctrl_write  = ctrl_msg[WR_LSB];
  assign ctrl_in     = ctrl_msg[IN_LSB +: IW];
  assign ctrl_out    = ctrl_msg[OUT_LSB +: OW];
  assign ctrl_en     = ctrl_msg[EN_LSB];
  // Padding bits below the en flag carry no meaning.
  assign unused_ctrl = ^ctrl_msg;
  assign tbl_wr      = ctrl_match(ctrl_val, ctrl_write,
                                  32'(ctrl_addr), 32'(BLOCK_ADDRESS),
                                  32'(ctrl_in), 32'(N_INPUTS),
                                  32'(ctrl_out), 32'(N_OUTPUTS));

  // Table write lands at the edge; the new route is seen from the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      route_en  <= '0;
      route_out <= '0;
    end else if (tbl_wr) begin
      route_en[ctrl_in]  <= ctrl_en;
      route_out[ctrl_in] <= ctrl_out;
    end
  end

  // Inputs buffer regardless of route state; only FIFO occupancy throttles them.
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_in
    assign push[i] = recv_val[i] && !full[i];
    crossbar_fifo #(
      .W     (BIT_WIDTH),
      .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[i]),
      .push_dat (recv_msg[i]),
      .pop      (pop[i]),
      .full     (full[i]),
      .empty    (empty[i]),
      .head     (head[i])
    );
  end

  assign recv_rdy = ~full;

  // Each non-empty, enabled input requests exactly the output its table entry names today.
  always_comb begin
    req = '0;
    for (int o = 0; o < N_OUTPUTS; o++) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        req[o][i] = !empty[i] && route_en[i] && (route_out[i] == OW'(o));
      end
    end
  end

  for (genvar o = 0; o < N_OUTPUTS; o++) begin : g_out
    xbar_rr_arbiter #(
      .N (N_INPUTS)
    ) u_arb (
      .req          (req[o]),
      .ptr          (ptr[o]),
      .lock         (lock[o]),
      .lock_idx     (lock_idx[o]),
      .grant_onehot (grant_oh[o]),
      .grant_idx    (grant_idx[o]),
      .any          (any_req[o])
    );
    assign send_val[o] = any_req[o];
    assign send_msg[o] = any_req[o] ? head[grant_idx[o]] : '0;
    assign xfer[o]     = any_req[o] && send_rdy[o];
  end

  // An input targets one output at most, so OR-ing grants never double-pops a FIFO.
  always_comb begin
    pop = '0;
    for (int o = 0; o < N_OUTPUTS; o++) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        pop[i] = pop[i] | (xfer[o] & grant_oh[o][i]);
      end
    end
  end

  // Pointer moves past the winner on transfer; a stalled beat locks its grant until it goes or is remapped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      lock     <= '0;
      lock_idx <= '0;
    end else begin
      for (int o = 0; o < N_OUTPUTS; o++) begin
        if (xfer[o]) begin
          ptr[o]  <= (grant_idx[o] == IW'(N_INPUTS - 1)) ? '0 : grant_idx[o] + IW'(1);
          lock[o] <= 1'b0;
        end else if (tbl_wr && lock[o] && (ctrl_in == lock_idx[o])) begin
          lock[o] <= 1'b0;
        end else if (send_val[o]) begin
          lock[o]     <= 1'b1;
          lock_idx[o] <= grant_idx[o];
        end
      end
    end
  end

endmodule

// File: tb/tb_crossbar_rr_router.sv
// Purpose: directed self-checking bench for crossbar_rr_router at default parameters.
// Latency: checks the 1-cycle accept-to-send path and same-cycle disjoint transfers.
// Backpressure: exercises full input FIFOs, output stalls with grant lock, and async reset.
module tb_crossbar_rr_router;
  import crossbar_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0][31:0] recv_msg;
  logic [3:0]       recv_val;
  logic [3:0]       recv_rdy;
  logic [3:0][31:0] send_msg;
  logic [3:0]       send_val;
  logic [3:0]       send_rdy;
  logic [31:0]      ctrl_msg;
  logic             ctrl_val;
  logic             ctrl_rdy;

  int total = 0;
  int bad   = 0;

  crossbar_rr_router dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .ctrl_msg (ctrl_msg),
    .ctrl_val (ctrl_val),
    .ctrl_rdy (ctrl_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cw(input logic [3:0] addr, input logic wr,
                                     input logic [1:0] in_i, input logic [1:0] out_i,
                                     input logic en);
    ctrl_word_t w;
    w         = '0;
    w.addr    = addr;
    w.write   = wr;
    w.in_idx  = in_i;
    w.out_idx = out_i;
    w.en      = en;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_send(input logic [31:0] w);
    ctrl_msg = w;
    ctrl_val = 1'b1;
    tick();
    ctrl_val = 1'b0;
    ctrl_msg = '0;
  endtask

  // in0 streams A0..A3 and in1 streams B0..B3 into out0; expected strict A/B alternation.
  task automatic run_stream(input string tag, input int stall_cycles);
    logic [31:0] expq [8];
    int ia, ib, got, stall;
    logic acc0, acc1, stalling;
    ia = 0; ib = 0; got = 0; stall = stall_cycles;
    for (int k = 0; k < 8; k++)
      expq[k] = (k % 2 == 0) ? 32'hA0 + 32'(k / 2) : 32'hB0 + 32'(k / 2);
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      recv_val[0] = (ia < 4);
      recv_msg[0] = 32'hA0 + 32'(ia);
      recv_val[1] = (ib < 4);
      recv_msg[1] = 32'hB0 + 32'(ib);
      stalling    = (stall > 0) && (got == 0) && (send_val[0] || stall < stall_cycles);
      send_rdy[0] = !stalling;
      if (stalling) stall--;
      @(negedge clk);
      acc0 = recv_val[0] && recv_rdy[0];
      acc1 = recv_val[1] && recv_rdy[1];
      if (stalling) begin
        chk({tag, "_hold_val"}, 32'(send_val[0]), 32'd1);
        chk({tag, "_hold_msg"}, send_msg[0], 32'hA0);
      end
      if (send_val[0] && send_rdy[0]) begin
        if (got < 8) chk({tag, "_seq"}, send_msg[0], expq[got]);
        got++;
      end
      @(posedge clk);
      #1;
      if (acc0) ia++;
      if (acc1) ib++;
    end
    recv_val    = '0;
    send_rdy[0] = 1'b1;
    chk({tag, "_count"}, 32'(got), 32'd8);
    chk({tag, "_idle"}, 32'(send_val[0]), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    recv_val = '0;
    recv_msg = '0;
    send_rdy = 4'hF;
    ctrl_msg = '0;
    ctrl_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_send_val", 32'(send_val), 32'd0);
    chk("rst_send_msg", 32'(|send_msg), 32'd0);
    chk("rst_recv_rdy", 32'(recv_rdy), 32'hF);
    chk("rst_ctrl_rdy", 32'(ctrl_rdy), 32'd1);
    reset = 1'b1;
    tick();

    // Test 1: unrouted input fills to depth 2, then stalls; later a route drains it.
    recv_val[0] = 1'b1;
    recv_msg[0] = 32'hA1;
    @(negedge clk);
    chk("t1_rdy_first", 32'(recv_rdy[0]), 32'd1);
    tick();
    recv_msg[0] = 32'hA2;
    @(negedge clk);
    chk("t1_rdy_second", 32'(recv_rdy[0]), 32'd1);
    chk("t1_no_val_a", 32'(send_val), 32'd0);
    tick();
    recv_msg[0] = 32'hA3;
    @(negedge clk);
    chk("t1_rdy_full", 32'(recv_rdy[0]), 32'd0);
    chk("t1_no_val_b", 32'(send_val), 32'd0);
    tick();
    recv_val = '0;
    ctrl_send(cw(4'd2, 1'b1, 2'd0, 2'd3, 1'b1));
    @(negedge clk);
    chk("t1_drain_val", 32'(send_val), 32'b1000);
    chk("t1_drain_a1", send_msg[3], 32'hA1);
    tick();
    @(negedge clk);
    chk("t1_drain_a2", send_msg[3], 32'hA2);
    chk("t1_rdy_back", 32'(recv_rdy[0]), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_drained", 32'(send_val), 32'd0);
    tick();

    // Test 2: disjoint paths in0->out1 and in1->out0 transfer together.
    ctrl_send(cw(4'd2, 1'b1, 2'd0, 2'd1, 1'b1));
    ctrl_send(cw(4'd2, 1'b1, 2'd1, 2'd0, 1'b1));
    recv_val    = 4'b0011;
    recv_msg[0] = 32'h11;
    recv_msg[1] = 32'h22;
    tick();
    recv_val = '0;
    @(negedge clk);
    chk("t2_val", 32'(send_val), 32'b0011);
    chk("t2_out1", send_msg[1], 32'h11);
    chk("t2_out0", send_msg[0], 32'h22);
    tick();
    @(negedge clk);
    chk("t2_empty", 32'(send_val), 32'd0);
    tick();

    // Tests 3 and 4: both inputs share out0, free-running then with a 3-cycle stall.
    ctrl_send(cw(4'd2, 1'b1, 2'd0, 2'd0, 1'b1));
    run_stream("t3", 0);
    run_stream("t4", 3);

    // Test 5: wrong address, read-type word, and unasserted valid leave the table alone.
    ctrl_send(cw(4'd3, 1'b1, 2'd0, 2'd2, 1'b1));
    ctrl_send(cw(4'd2, 1'b0, 2'd0, 2'd2, 1'b1));
    ctrl_msg = cw(4'd2, 1'b1, 2'd0, 2'd2, 1'b1);
    tick();
    ctrl_msg = '0;
    recv_val[0] = 1'b1;
    recv_msg[0] = 32'h55;
    tick();
    recv_val = '0;
    @(negedge clk);
    chk("t5_val", 32'(send_val), 32'b0001);
    chk("t5_msg", send_msg[0], 32'h55);
    tick();
    ctrl_send(cw(4'd2, 1'b1, 2'd0, 2'd0, 1'b0));
    recv_val[0] = 1'b1;
    recv_msg[0] = 32'h66;
    tick();
    recv_val = '0;
    @(negedge clk);
    chk("t5_disabled", 32'(send_val), 32'd0);
    tick();

    // Test 6: async reset mid-stream clears outputs at once, then table and FIFOs.
    send_rdy[0] = 1'b0;
    recv_val[1] = 1'b1;
    recv_msg[1] = 32'h77;
    tick();
    recv_val = '0;
    @(negedge clk);
    chk("t6_pre_val", 32'(send_val), 32'b0001);
    chk("t6_pre_msg", send_msg[0], 32'h77);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_async_val", 32'(send_val), 32'd0);
    chk("t6_async_msg", send_msg[0], 32'd0);
    chk("t6_async_rdy", 32'(recv_rdy), 32'hF);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    send_rdy = 4'hF;
    @(negedge clk);
    chk("t6_post_val", 32'(send_val), 32'd0);
    tick();
    recv_val    = 4'b0011;
    recv_msg[0] = 32'h88;
    recv_msg[1] = 32'h88;
    tick();
    recv_val = '0;
    @(negedge clk);
    chk("t6_routes_off", 32'(send_val), 32'd0);
    tick();
    ctrl_send(cw(4'd2, 1'b1, 2'd1, 2'd2, 1'b1));
    @(negedge clk);
    chk("t6_fresh_val", 32'(send_val), 32'b0100);
    chk("t6_fresh_msg", send_msg[2], 32'h88);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
